// File: rtl/nv_fifo_ctrl_rwsp_16x14_pkg.sv
// Shared sizing and payload types for the 16x14 flop-RAM FIFO controller.
package nv_fifo_ctrl_rwsp_16x14_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_WIDTH = 14;
  localparam int unsigned FIFO_AW    = 4;
  localparam int unsigned FIFO_CW    = FIFO_AW + 1;
  localparam int unsigned PWR_W      = 32;

  typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
  typedef logic [FIFO_AW-1:0]    fifo_addr_t;
  typedef logic [FIFO_CW-1:0]    fifo_cnt_t;

  // RAM write-port bundle
  typedef struct packed {
    logic       vld;
    fifo_addr_t addr;
    fifo_data_t data;
  } ram_wr_t;

endpackage

// File: rtl/nv_fifo_rd_pipe.sv
// Two-stage read pipeline tracker for a RAM with a registered address and a
// registered output: generates address-latch and output-register enables.
module nv_fifo_rd_pipe (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic i_avail,
  input  logic i_out_rdy,
  output logic o_re,
  output logic o_ore,
  output logic o_vld
);

  logic r_s1_vld;
  logic r_s2_vld;
  logic w_re;
  logic w_ore;

  // Advance a stage only when the stage downstream is free or draining
  always_comb begin
    w_ore = r_s1_vld & (~r_s2_vld | i_out_rdy);
    w_re  = i_avail & (~r_s1_vld | w_ore);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_re)       r_s1_vld <= 1'b1;
      else if (w_ore) r_s1_vld <= 1'b0;
      if (w_ore)          r_s2_vld <= 1'b1;
      else if (i_out_rdy) r_s2_vld <= 1'b0;
    end
  end

  assign o_re  = w_re;
  assign o_ore = w_ore;
  assign o_vld = r_s2_vld;

endmodule

// File: rtl/nv_fifo_ctrl_rwsp_16x14.sv
// Valid/ready FIFO controller sequencing an external 16x14 two-port RAM with
// registered read address and registered output.
module nv_fifo_ctrl_rwsp_16x14
  import nv_fifo_ctrl_rwsp_16x14_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [13:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [13:0] rd_pd,
  output logic [4:0]  fifo_count,
  output logic [3:0]  ram_wa,
  output logic        ram_we,
  output logic [13:0] ram_di,
  output logic [3:0]  ram_ra,
  output logic        ram_re,
  output logic        ram_ore,
  input  logic [13:0] ram_dout,
  input  logic [31:0] pwrbus_ram_pd,
  output logic [31:0] ram_pwrbus_ram_pd
);

  fifo_addr_t r_wr_ptr;
  fifo_addr_t r_rd_ptr;
  fifo_cnt_t  r_count;
  fifo_cnt_t  r_unread;
  logic       r_wr_prdy;

  logic       w_push;
  logic       w_pop;
  logic       w_re;
  logic       w_ore;
  logic       w_rd_vld;
  logic       w_avail;
  fifo_cnt_t  w_count_nxt;
  fifo_cnt_t  w_unread_nxt;
  ram_wr_t    w_wr_port;

  always_comb begin
    w_push       = wr_pvld & r_wr_prdy;
    w_pop        = w_rd_vld & rd_prdy;
    w_avail      = (r_unread != '0);
    w_count_nxt  = r_count + FIFO_CW'(w_push) - FIFO_CW'(w_pop);
    w_unread_nxt = r_unread + FIFO_CW'(w_push) - FIFO_CW'(w_re);
  end

  // Entries stay counted until popped, so a slot is never reused while in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_unread  <= '0;
      r_wr_prdy <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_unread  <= '0;
      r_wr_prdy <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_re)   r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count   <= w_count_nxt;
      r_unread  <= w_unread_nxt;
      r_wr_prdy <= (w_count_nxt < FIFO_CW'(FIFO_DEPTH));
    end
  end

  nv_fifo_rd_pipe u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .i_avail   (w_avail),
    .i_out_rdy (rd_prdy),
    .o_re      (w_re),
    .o_ore     (w_ore),
    .o_vld     (w_rd_vld)
  );

  always_comb begin
    w_wr_port.vld  = w_push;
    w_wr_port.addr = r_wr_ptr;
    w_wr_port.data = wr_pd;
  end

  assign ram_we            = w_wr_port.vld;
  assign ram_wa            = w_wr_port.addr;
  assign ram_di            = w_wr_port.data;
  assign ram_ra            = r_rd_ptr;
  assign ram_re            = w_re;
  assign ram_ore           = w_ore;
  assign rd_pvld           = w_rd_vld;
  assign rd_pd             = ram_dout;
  assign wr_prdy           = r_wr_prdy;
  assign fifo_count        = r_count;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule
